// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint controller for the single-cycle CPU: sequences CPU reset,
// gates per-cycle instruction commit, halts on PC breakpoints, counts commits.
module cpu_run_ctrl #(
    parameter int unsigned PC_W       = 32,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned NUM_BP     = 2,
    parameter int unsigned RST_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [CNT_W-1:0]         cmd_arg,
    input  logic [NUM_BP-1:0]        bp_en,
    input  logic [NUM_BP*PC_W-1:0]   bp_addr,
    input  logic [PC_W-1:0]          pc,
    output logic                     cpu_rst,
    output logic                     cpu_en,
    output logic                     halted,
    output logic [NUM_BP-1:0]        bp_hit,
    output logic [CNT_W-1:0]         cycle_cnt
);

    localparam int unsigned RCNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_RESET,
        S_HALT,
        S_RUN,
        S_STEP
    } state_t;

    typedef enum logic [1:0] {
        OP_RUN   = 2'b00,
        OP_STEP  = 2'b01,
        OP_HALT  = 2'b10,
        OP_RESET = 2'b11
    } op_t;

    state_t             r_state;
    logic [RCNT_W-1:0]  r_rcnt;
    logic [CNT_W-1:0]   r_scnt;
    logic [CNT_W-1:0]   r_cycle_cnt;
    logic [NUM_BP-1:0]  r_bp_hit;
    logic               r_skip;

    logic [NUM_BP-1:0]  w_hit_vec;
    logic               w_match;
    logic               w_en;
    logic               w_ready;
    logic               w_accept;
    op_t                w_op;

    always_comb begin
        w_hit_vec = '0;
        for (int unsigned i = 0; i < NUM_BP; i++) begin
            w_hit_vec[i] = bp_en[i] && (bp_addr[i*PC_W +: PC_W] == pc);
        end
    end

    // skip masks the breakpoint the CPU is parked on so RUN can move past it
    assign w_match  = (r_state == S_RUN) && (|w_hit_vec) && !r_skip;
    assign w_en     = !rst && (((r_state == S_RUN) && !w_match) || (r_state == S_STEP));
    assign w_ready  = !rst && (r_state != S_RESET);
    assign w_accept = cmd_valid && w_ready;
    assign w_op     = op_t'(cmd_op);

    assign cpu_rst   = rst || (r_state == S_RESET);
    assign cpu_en    = w_en;
    assign halted    = !rst && (r_state == S_HALT);
    assign cmd_ready = w_ready;
    assign bp_hit    = r_bp_hit;
    assign cycle_cnt = r_cycle_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_RESET;
            r_rcnt      <= RCNT_W'(RST_CYCLES - 1);
            r_scnt      <= '0;
            r_cycle_cnt <= '0;
            r_bp_hit    <= '0;
            r_skip      <= 1'b0;
        end else begin
            if (w_en) begin
                r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            end

            case (r_state)
                S_RESET: begin
                    r_cycle_cnt <= '0;
                    r_bp_hit    <= '0;
                    if (r_rcnt == '0) begin
                        r_state <= S_HALT;
                    end else begin
                        r_rcnt <= r_rcnt - RCNT_W'(1);
                    end
                end
                S_RUN: begin
                    r_skip <= 1'b0;
                    if (w_match) begin
                        r_bp_hit <= w_hit_vec;
                        r_state  <= S_HALT;
                    end
                end
                S_STEP: begin
                    r_scnt <= r_scnt - CNT_W'(1);
                    if (r_scnt <= CNT_W'(1)) begin
                        r_state <= S_HALT;
                    end
                end
                default: ;
            endcase

            // an accepted command overrides the state's own next-state choice
            if (w_accept) begin
                case (w_op)
                    OP_RUN: begin
                        if (r_state != S_RUN) begin
                            r_state  <= S_RUN;
                            r_bp_hit <= '0;
                            r_skip   <= (r_state == S_HALT);
                        end
                    end
                    OP_STEP: begin
                        r_state  <= S_STEP;
                        r_scnt   <= (cmd_arg == '0) ? CNT_W'(1) : cmd_arg;
                        r_bp_hit <= '0;
                    end
                    OP_HALT: begin
                        r_state <= S_HALT;
                    end
                    default: begin
                        r_state <= S_RESET;
                        r_rcnt  <= RCNT_W'(RST_CYCLES - 1);
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: emulates a CPU whose PC advances by 4 per commit and
// scores every halt against expectations queued when the command was issued.
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_arg;
    logic [1:0]  bp_en;
    logic [63:0] bp_addr;
    logic [31:0] pc;
    logic        cpu_rst;
    logic        cpu_en;
    logic        halted;
    logic [1:0]  bp_hit;
    logic [31:0] cycle_cnt;

    always #5 clk = ~clk;

    cpu_run_ctrl #(
        .PC_W      (32),
        .CNT_W     (32),
        .NUM_BP    (2),
        .RST_CYCLES(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_arg  (cmd_arg),
        .bp_en    (bp_en),
        .bp_addr  (bp_addr),
        .pc       (pc),
        .cpu_rst  (cpu_rst),
        .cpu_en   (cpu_en),
        .halted   (halted),
        .bp_hit   (bp_hit),
        .cycle_cnt(cycle_cnt)
    );

    typedef struct {
        string       name;
        int unsigned en0;
        int unsigned rst0;
        int unsigned exp_en;
        int unsigned exp_rst;
        logic [31:0] exp_cycle;
        logic [31:0] exp_pc;
        logic [1:0]  exp_bp;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned n_en  = 0;
    int unsigned n_rst = 0;
    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_cycle;
    logic [31:0] m_pc;
    logic        prev_h = 1'b0;

    // CPU model: PC restarts at 0 under reset and advances on each commit
    always @(posedge clk) begin
        if (cpu_rst) pc <= 32'h0;
        else if (cpu_en) pc <= pc + 32'd4;
        if (cpu_en === 1'b1) n_en++;
        if (cpu_rst === 1'b1 && rst === 1'b0) n_rst++;
    end

    // Scoreboard monitor: every rising edge of halted consumes one expectation
    always @(negedge clk) begin
        if (halted === 1'b1 && prev_h === 1'b0) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_halt: got halt with empty queue, want none");
            end else begin
                mon_e = sb.pop_front();
                total++;
                if (n_en - mon_e.en0 !== mon_e.exp_en) begin
                    bad++;
                    $display("FAIL %s commits: got %0d want %0d", mon_e.name, n_en - mon_e.en0, mon_e.exp_en);
                end
                total++;
                if (n_rst - mon_e.rst0 !== mon_e.exp_rst) begin
                    bad++;
                    $display("FAIL %s cpu_rst_cycles: got %0d want %0d", mon_e.name, n_rst - mon_e.rst0, mon_e.exp_rst);
                end
                total++;
                if (cycle_cnt !== mon_e.exp_cycle) begin
                    bad++;
                    $display("FAIL %s cycle_cnt: got %0d want %0d", mon_e.name, cycle_cnt, mon_e.exp_cycle);
                end
                total++;
                if (pc !== mon_e.exp_pc) begin
                    bad++;
                    $display("FAIL %s pc: got %h want %h", mon_e.name, pc, mon_e.exp_pc);
                end
                total++;
                if (bp_hit !== mon_e.exp_bp) begin
                    bad++;
                    $display("FAIL %s bp_hit: got %b want %b", mon_e.name, bp_hit, mon_e.exp_bp);
                end
            end
        end
        prev_h = halted;
    end

    task automatic push_exp(input string name, input int unsigned exp_en,
                            input int unsigned exp_rst, input logic [1:0] exp_bp);
        exp_t e;
        e.name      = name;
        e.en0       = n_en;
        e.rst0      = n_rst;
        e.exp_en    = exp_en;
        e.exp_rst   = exp_rst;
        e.exp_cycle = m_cycle;
        e.exp_pc    = m_pc;
        e.exp_bp    = exp_bp;
        sb.push_back(e);
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [31:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound);
        for (int i = 0; i < bound; i++) begin
            @(posedge clk);
            if (sb.size() == 0) break;
        end
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s timeout: got %0d pending halts, want 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_arg = '0;
        bp_en = 2'b00; bp_addr = '0;
        m_cycle = 0; m_pc = 0;
        push_exp("reset", 0, 4, 2'b00);
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if ({cpu_rst, cpu_en, halted, cmd_ready} !== 4'b1000) begin
            bad++;
            $display("FAIL reset_outputs: got rst/en/halt/rdy=%b want 1000", {cpu_rst, cpu_en, halted, cmd_ready});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        wait_done("reset", 40);
        total++;
        if (cmd_ready !== 1'b1 || halted !== 1'b1) begin
            bad++;
            $display("FAIL reset_halt_ready: got halted=%b ready=%b want 1 1", halted, cmd_ready);
        end
    endtask

    task automatic test_step(input logic [31:0] arg);
        int unsigned n;
        n = (arg == 0) ? 1 : arg;
        m_cycle += n; m_pc += 4 * n;
        push_exp($sformatf("step%0d", arg), n, 0, 2'b00);
        send_cmd(2'b01, arg);
        wait_done("step", 40);
    endtask

    task automatic test_back_to_back();
        m_cycle += 3; m_pc += 12;
        push_exp("run_then_step2", 3, 0, 2'b00);
        send_cmd(2'b00, '0);
        send_cmd(2'b01, 32'd2);
        wait_done("run_then_step2", 40);
    endtask

    task automatic test_run_halt();
        m_cycle += 6; m_pc += 24;
        push_exp("run_halt", 6, 0, 2'b00);
        send_cmd(2'b00, '0);
        repeat (5) @(posedge clk);
        #1;
        send_cmd(2'b10, '0);
        @(negedge clk);
        total++;
        if (halted !== 1'b1) begin
            bad++;
            $display("FAIL halt_next_cycle: got halted=%b want 1", halted);
        end
        wait_done("run_halt", 10);
    endtask

    task automatic test_reset_cmd();
        m_cycle = 0; m_pc = 0;
        push_exp("reset_cpu", 0, 4, 2'b00);
        send_cmd(2'b11, '0);
        wait_done("reset_cpu", 40);
    endtask

    task automatic test_breakpoint();
        bp_en   = 2'b11;
        bp_addr = {32'h0000_0018, 32'h0000_0010};
        m_cycle += 4; m_pc = 32'h10;
        push_exp("bp0", 4, 0, 2'b01);
        send_cmd(2'b00, '0);
        wait_done("bp0", 40);
        m_cycle += 2; m_pc = 32'h18;
        push_exp("bp1_resume", 2, 0, 2'b10);
        send_cmd(2'b00, '0);
        wait_done("bp1_resume", 40);
        bp_addr = {32'h0000_0020, 32'h0000_0020};
        m_cycle += 2; m_pc = 32'h20;
        push_exp("bp_both", 2, 0, 2'b11);
        send_cmd(2'b00, '0);
        wait_done("bp_both", 40);
        m_cycle += 1; m_pc = 32'h24;
        push_exp("step_over_bp", 1, 0, 2'b00);
        send_cmd(2'b01, 32'd1);
        wait_done("step_over_bp", 40);
        bp_en = 2'b00;
    endtask

    task automatic test_rst_mid_step();
        send_cmd(2'b01, 32'd100);
        repeat (5) @(posedge clk);
        @(negedge clk);
        total++;
        if (cpu_en !== 1'b1) begin
            bad++;
            $display("FAIL step100_running: got cpu_en=%b want 1", cpu_en);
        end
        @(posedge clk); #1;
        m_cycle = 0; m_pc = 0;
        push_exp("rst_mid_step", 0, 4, 2'b00);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({cpu_rst, cpu_en, halted, cmd_ready} !== 4'b1000) begin
            bad++;
            $display("FAIL rst_mid_step_outputs: got rst/en/halt/rdy=%b want 1000", {cpu_rst, cpu_en, halted, cmd_ready});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        wait_done("rst_mid_step", 40);
    endtask

    initial begin
        test_reset();
        test_step(32'd3);
        test_step(32'd0);
        test_back_to_back();
        test_run_halt();
        test_reset_cmd();
        test_breakpoint();
        test_rst_mid_step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
